apb_timeout_guard: RTL and testbench



---
 rtl/apb_timeout_guard_pkg.sv | 19 +
 rtl/apb_timeout_guard_if.sv | 35 +++
 rtl/apb_timeout_guard.sv | 189 ++++++++++++++++++
 tb/tb_apb_timeout_guard.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timeout_guard_pkg.sv
// rtl/apb_timeout_guard_pkg.sv - APB bus widths and guard FSM state type shared by the guard bundle.
package apb_timeout_guard_pkg;

  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_STRB_W  = APB_DATA_W / 8;
  localparam int APB_AUSER_W = 4;
  localparam int APB_WUSER_W = 4;
  localparam int APB_RUSER_W = 4;
  localparam int APB_BUSER_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    ORPHAN
  } apb_guard_state_t;

endpackage

// File: rtl/apb_timeout_guard_if.sv
// rtl/apb_timeout_guard_if.sv - APB bus bundle with requester and completer views.
interface apb_timeout_guard_if;
  import apb_timeout_guard_pkg::*;

  logic                   pclk;
  logic                   preset_n;
  logic                   psel;
  logic                   penable;
  logic [APB_ADDR_W-1:0]  paddr;
  logic                   pwrite;
  logic [APB_DATA_W-1:0]  pwdata;
  logic [2:0]             pprot;
  logic [APB_STRB_W-1:0]  pstrb;
  logic                   pwakeup;
  logic [APB_AUSER_W-1:0] pauser;
  logic [APB_WUSER_W-1:0] pwuser;
  logic [APB_DATA_W-1:0]  prdata;
  logic                   pready;
  logic                   pslverr;
  logic [APB_RUSER_W-1:0] pruser;
  logic [APB_BUSER_W-1:0] pbuser;

  modport completer (
    input  pclk, preset_n, psel, penable, paddr, pwrite, pwdata, pprot, pstrb,
           pwakeup, pauser, pwuser,
    output prdata, pready, pslverr, pruser, pbuser
  );

  modport requester (
    output pclk, preset_n, psel, penable, paddr, pwrite, pwdata, pprot, pstrb,
           pwakeup, pauser, pwuser,
    input  prdata, pready, pslverr, pruser, pbuser
  );

endinterface

// File: rtl/apb_timeout_guard.sv
// rtl/apb_timeout_guard.sv - APB register stage that error-completes hung transfers and absorbs late responses.
// Optional status outputs (timeout_count, last_timeout_addr) under APB_TIMEOUT_GUARD_STATUS_EN.
module apb_timeout_guard
  import apb_timeout_guard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  apb_timeout_guard_if.completer upstream,
  apb_timeout_guard_if.requester downstream,
  output logic                   timed_out
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
  ,
  output logic [15:0]            timeout_count,
  output logic [APB_ADDR_W-1:0]  last_timeout_addr
`endif
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic clk;
  logic rst_n;

  assign clk                 = upstream.pclk;
  assign rst_n               = upstream.preset_n;
  assign downstream.pclk     = clk;
  assign downstream.preset_n = rst_n;

  apb_guard_state_t      state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  ds_psel_q, ds_psel_d;
  logic                  ds_penable_q, ds_penable_d;
  logic                  capture;

  logic [APB_ADDR_W-1:0]  ds_paddr_q;
  logic                   ds_pwrite_q;
  logic [APB_DATA_W-1:0]  ds_pwdata_q;
  logic [2:0]             ds_pprot_q;
  logic [APB_STRB_W-1:0]  ds_pstrb_q;
  logic                   ds_pwakeup_q;
  logic [APB_AUSER_W-1:0] ds_pauser_q;
  logic [APB_WUSER_W-1:0] ds_pwuser_q;

  logic                   us_pready_q, us_pready_d;
  logic                   us_pslverr_q, us_pslverr_d;
  logic [APB_DATA_W-1:0]  us_prdata_q, us_prdata_d;
  logic [APB_RUSER_W-1:0] us_pruser_q, us_pruser_d;
  logic [APB_BUSER_W-1:0] us_pbuser_q, us_pbuser_d;
  logic                   timed_out_q, timed_out_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ds_psel_d    = ds_psel_q;
    ds_penable_d = ds_penable_q;
    capture      = 1'b0;
    us_pready_d  = 1'b0;
    us_pslverr_d = us_pslverr_q;
    us_prdata_d  = us_prdata_q;
    us_pruser_d  = us_pruser_q;
    us_pbuser_d  = us_pbuser_q;
    timed_out_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // The !pready term keeps the completion cycle from being mistaken for a new access.
        if (upstream.psel && upstream.penable && !us_pready_q) begin
          capture      = 1'b1;
          ds_psel_d    = 1'b1;
          ds_penable_d = 1'b0;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        ds_penable_d = 1'b1;
        cnt_d        = '0;
        state_d      = ACCESS;
      end
      ACCESS: begin
        if (downstream.pready) begin
          us_pready_d  = 1'b1;
          us_pslverr_d = downstream.pslverr;
          us_prdata_d  = downstream.prdata;
          us_pruser_d  = downstream.pruser;
          us_pbuser_d  = downstream.pbuser;
          ds_psel_d    = 1'b0;
          ds_penable_d = 1'b0;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Downstream keeps psel/penable: an APB access cannot be withdrawn.
          us_pready_d  = 1'b1;
          us_pslverr_d = 1'b1;
          us_prdata_d  = '0;
          us_pruser_d  = '0;
          us_pbuser_d  = '0;
          timed_out_d  = 1'b1;
          state_d      = ORPHAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ORPHAN: begin
        if (downstream.pready) begin
          ds_psel_d    = 1'b0;
          ds_penable_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ds_psel_q    <= 1'b0;
      ds_penable_q <= 1'b0;
      ds_paddr_q   <= '0;
      ds_pwrite_q  <= 1'b0;
      ds_pwdata_q  <= '0;
      ds_pprot_q   <= '0;
      ds_pstrb_q   <= '0;
      ds_pwakeup_q <= 1'b0;
      ds_pauser_q  <= '0;
      ds_pwuser_q  <= '0;
      us_pready_q  <= 1'b0;
      us_pslverr_q <= 1'b0;
      us_prdata_q  <= '0;
      us_pruser_q  <= '0;
      us_pbuser_q  <= '0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ds_psel_q    <= ds_psel_d;
      ds_penable_q <= ds_penable_d;
      us_pready_q  <= us_pready_d;
      us_pslverr_q <= us_pslverr_d;
      us_prdata_q  <= us_prdata_d;
      us_pruser_q  <= us_pruser_d;
      us_pbuser_q  <= us_pbuser_d;
      timed_out_q  <= timed_out_d;
      if (capture) begin
        ds_paddr_q   <= upstream.paddr;
        ds_pwrite_q  <= upstream.pwrite;
        ds_pwdata_q  <= upstream.pwdata;
        ds_pprot_q   <= upstream.pprot;
        ds_pstrb_q   <= upstream.pstrb;
        ds_pwakeup_q <= upstream.pwakeup;
        ds_pauser_q  <= upstream.pauser;
        ds_pwuser_q  <= upstream.pwuser;
      end
    end
  end

  assign downstream.psel    = ds_psel_q;
  assign downstream.penable = ds_penable_q;
  assign downstream.paddr   = ds_paddr_q;
  assign downstream.pwrite  = ds_pwrite_q;
  assign downstream.pwdata  = ds_pwdata_q;
  assign downstream.pprot   = ds_pprot_q;
  assign downstream.pstrb   = ds_pstrb_q;
  assign downstream.pwakeup = ds_pwakeup_q;
  assign downstream.pauser  = ds_pauser_q;
  assign downstream.pwuser  = ds_pwuser_q;

  assign upstream.pready  = us_pready_q;
  assign upstream.pslverr = us_pslverr_q;
  assign upstream.prdata  = us_prdata_q;
  assign upstream.pruser  = us_pruser_q;
  assign upstream.pbuser  = us_pbuser_q;
  assign timed_out        = timed_out_q;

`ifdef APB_TIMEOUT_GUARD_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count     <= '0;
      last_timeout_addr <= '0;
    end else if (timed_out_d) begin
      if (timeout_count != 16'hffff) begin
        timeout_count <= timeout_count + 16'd1;
      end
      last_timeout_addr <= ds_paddr_q;
    end
  end
`endif

endmodule

// File: tb/tb_apb_timeout_guard.sv
// tb/tb_apb_timeout_guard.sv - Self-checking bench for apb_timeout_guard with TIMEOUT_CYCLES=16.
module tb_apb_timeout_guard;
  import apb_timeout_guard_pkg::*;

  localparam int T = 16;

  typedef struct {
    int          wait_st;
    logic [31:0] rdata;
    logic        slverr;
  } cfg_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [2:0]  prot;
    logic [3:0]  strb;
    logic        wake;
    logic [3:0]  auser;
    logic [3:0]  wuser;
  } req_t;

  apb_timeout_guard_if up ();
  apb_timeout_guard_if dn ();
  logic timed_out;
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
  logic [15:0] timeout_count;
  logic [31:0] last_timeout_addr;
`endif

  apb_timeout_guard #(.TIMEOUT_CYCLES(T)) dut (
    .upstream          (up),
    .downstream        (dn),
    .timed_out         (timed_out)
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    ,
    .timeout_count     (timeout_count),
    .last_timeout_addr (last_timeout_addr)
`endif
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   to_seen = 0;
  cfg_t cq[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  initial begin
    up.pclk = 1'b0;
    forever #5 up.pclk = ~up.pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Completer: each transfer takes its wait-state count from the queue; -1 never answers.
  initial begin
    automatic int   acc = 0;
    automatic cfg_t cur = '{-1, 32'h0, 1'b0};
    dn.pready = 1'b0; dn.prdata = '0; dn.pslverr = 1'b0; dn.pruser = '0; dn.pbuser = '0;
    forever begin
      @(posedge up.pclk); #1;
      if (up.preset_n && dn.psel && dn.penable) begin
        acc++;
        if (acc == 1) begin
          if (cq.size() > 0) cur = cq.pop_front();
          else cur = '{-1, 32'h0, 1'b0};
        end
        dn.pready  = (cur.wait_st == acc - 1);
        dn.prdata  = cur.rdata;
        dn.pslverr = cur.slverr;
        dn.pruser  = cur.rdata[3:0];
        dn.pbuser  = cur.rdata[7:4];
      end else begin
        acc = 0;
        dn.pready = 1'b0;
      end
    end
  end

  // Reference model: timestamps of setup/response/timeout derived from the transfer rules.
  initial begin
    automatic bit          m_active = 0;
    automatic bit          m_orphan = 0;
    automatic int          m_t0 = 0;
    automatic int          rsp_cyc = -1;
    automatic int          to_cyc = -1;
    automatic req_t        m_req = '{32'h0, 1'b0, 32'h0, 3'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    automatic logic [31:0] r_data = 0;
    automatic logic        r_err = 0;
    automatic logic [3:0]  r_ruser = 0;
    automatic logic [3:0]  r_buser = 0;
    automatic bit          exp_upr;
    automatic int          k;
    forever begin
      @(negedge up.pclk);
      cyc++;
      if (timed_out === 1'b1) to_seen++;
      if (!up.preset_n) begin
        chk("rst_us_pready", up.pready, 0);
        chk("rst_us_pslverr", up.pslverr, 0);
        chk("rst_us_prdata", up.prdata, 0);
        chk("rst_ds_psel", dn.psel, 0);
        chk("rst_ds_penable", dn.penable, 0);
        chk("rst_ds_paddr", dn.paddr, 0);
        chk("rst_timed_out", timed_out, 0);
        m_active = 0; m_orphan = 0; rsp_cyc = -1; to_cyc = -1;
      end else begin
        exp_upr = (cyc == rsp_cyc);
        chk("ds_psel", dn.psel, m_active);
        chk("ds_penable", dn.penable, m_active && cyc > m_t0);
        chk("us_pready", up.pready, exp_upr);
        chk("timed_out", timed_out, cyc == to_cyc);
        if (exp_upr) begin
          chk("us_prdata", up.prdata, r_data);
          chk("us_pslverr", up.pslverr, r_err);
          chk("us_pruser", up.pruser, r_ruser);
          chk("us_pbuser", up.pbuser, r_buser);
        end
        if (m_active) begin
          chk("ds_paddr", dn.paddr, m_req.addr);
          chk("ds_pwrite", dn.pwrite, m_req.wr);
          chk("ds_pwdata", dn.pwdata, m_req.wdata);
          chk("ds_pprot", dn.pprot, m_req.prot);
          chk("ds_pstrb", dn.pstrb, m_req.strb);
          chk("ds_pwakeup", dn.pwakeup, m_req.wake);
          chk("ds_pauser", dn.pauser, m_req.auser);
          chk("ds_pwuser", dn.pwuser, m_req.wuser);
        end
        if (m_active && cyc > m_t0) begin
          k = cyc - m_t0 - 1;
          if (dn.pready) begin
            m_active = 0;
            if (!m_orphan) begin
              rsp_cyc = cyc + 1;
              r_data = dn.prdata; r_err = dn.pslverr; r_ruser = dn.pruser; r_buser = dn.pbuser;
            end
            m_orphan = 0;
          end else if (!m_orphan && k == T - 1) begin
            m_orphan = 1;
            rsp_cyc = cyc + 1;
            to_cyc = cyc + 1;
            r_data = 0; r_err = 1; r_ruser = 0; r_buser = 0;
          end
        end else if (!m_active && up.psel && up.penable && !exp_upr) begin
          m_active = 1;
          m_t0 = cyc + 1;
          m_req = '{up.paddr, up.pwrite, up.pwdata, up.pprot, up.pstrb, up.pwakeup, up.pauser, up.pwuser};
        end
      end
    end
  end

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    up.pwrite  = wr;
    up.paddr   = addr;
    up.pwdata  = wdata;
    up.pprot   = addr[6:4];
    up.pstrb   = addr[7:4] ^ 4'h3;
    up.pwakeup = 1'b1;
    up.pauser  = addr[7:4];
    up.pwuser  = wdata[3:0];
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    automatic bit done = 0;
    @(posedge up.pclk); #1;
    up.psel = 1'b1; up.penable = 1'b0;
    drive_req(wr, addr, wdata);
    @(posedge up.pclk); #1;
    up.penable = 1'b1;
    lat = 0;
    while (!done && lat < 300) begin
      @(negedge up.pclk);
      if (up.pready) done = 1;
      else lat++;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL xfer_timeout: no upstream pready for addr %0h within 300 cycles", addr);
    end
    rdata = up.prdata;
    err   = up.pslverr;
    @(posedge up.pclk); #1;
    up.psel = 1'b0; up.penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    up.preset_n = 1'b0;
    up.psel = 1'b0; up.penable = 1'b0;
    drive_req(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge up.pclk);
    #1;
    chk("reset_us_pready", up.pready, 0);
    chk("reset_us_prdata", up.prdata, 0);
    chk("reset_ds_psel", dn.psel, 0);
    chk("reset_ds_pwdata", dn.pwdata, 0);
    chk("reset_timed_out", timed_out, 0);
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    chk("reset_timeout_count", timeout_count, 0);
    chk("reset_last_timeout_addr", last_timeout_addr, 0);
`endif
    @(posedge up.pclk); #3;
    up.preset_n = 1'b1;

    // Write, response in the 2nd access cycle.
    cq.push_back('{1, 32'h0000_00A5, 1'b0});
    xfer(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("t1_latency", lat, 4);
    chk("t1_pslverr", er, 0);

    // Read with completer error after 5 wait states.
    cq.push_back('{5, 32'h1234_5678, 1'b1});
    xfer(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("t2_latency", lat, 8);
    chk("t2_prdata", rd, 32'h1234_5678);
    chk("t2_pslverr", er, 1);
    chk("t2_no_timeout", to_seen, 0);

    // Hung read: error completion, then the late reply is absorbed while a write stalls.
    cq.push_back('{55, 32'hAAAA_5555, 1'b0});
    cq.push_back('{0, 32'h1111_0000, 1'b0});
    xfer(1'b0, 32'h30, 32'h0, rd, er, lat);
    chk("t3_latency", lat, 18);
    chk("t3_prdata", rd, 0);
    chk("t3_pslverr", er, 1);
    chk("t3_timeout_pulses", to_seen, 1);
    chk("t3_ds_psel_held", dn.psel, 1);
    chk("t3_ds_penable_held", dn.penable, 1);
    xfer(1'b1, 32'h44, 32'h0BAD_F00D, rd, er, lat);
    chk("t4_latency", lat, 40);
    chk("t4_prdata", rd, 32'h1111_0000);
    chk("t4_pslverr", er, 0);

    // Reply lands on the last allowed access cycle.
    cq.push_back('{15, 32'hCAFE_0001, 1'b1});
    xfer(1'b0, 32'h50, 32'h0, rd, er, lat);
    chk("t5_latency", lat, 18);
    chk("t5_prdata", rd, 32'hCAFE_0001);
    chk("t5_pslverr", er, 1);
    chk("t5_no_timeout", to_seen, 1);

    // Second timeout, then reset while orphaned.
    cq.push_back('{-1, 32'h0, 1'b0});
    xfer(1'b0, 32'h60, 32'h0, rd, er, lat);
    chk("t6_latency", lat, 18);
    chk("t6_pslverr", er, 1);
    chk("t6_timeout_pulses", to_seen, 2);
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    chk("t6_timeout_count", timeout_count, 2);
    chk("t6_last_timeout_addr", last_timeout_addr, 32'h60);
`endif
    repeat (3) @(posedge up.pclk);
    #3;
    chk("t6_orphan_psel", dn.psel, 1);
    up.preset_n = 1'b0;
    #1;
    chk("t6_async_psel", dn.psel, 0);
    chk("t6_async_penable", dn.penable, 0);
    chk("t6_async_paddr", dn.paddr, 0);
`ifdef APB_TIMEOUT_GUARD_STATUS_EN
    chk("t6_async_timeout_count", timeout_count, 0);
`endif
    @(posedge up.pclk); #3;
    up.preset_n = 1'b1;

    cq.push_back('{0, 32'h7777_0007, 1'b0});
    xfer(1'b1, 32'h70, 32'h0000_7070, rd, er, lat);
    chk("t7_latency", lat, 3);
    chk("t7_pslverr", er, 0);

    // Reset while in access phase with a silent completer.
    cq.push_back('{-1, 32'h0, 1'b0});
    @(posedge up.pclk); #1;
    up.psel = 1'b1; up.penable = 1'b0;
    drive_req(1'b0, 32'h80, 32'h0);
    @(posedge up.pclk); #1;
    up.penable = 1'b1;
    repeat (6) @(posedge up.pclk);
    #3;
    chk("t8_access_penable", dn.penable, 1);
    up.preset_n = 1'b0;
    #1;
    chk("t8_async_psel", dn.psel, 0);
    chk("t8_async_penable", dn.penable, 0);
    chk("t8_async_us_pready", up.pready, 0);
    @(posedge up.pclk); #1;
    up.psel = 1'b0; up.penable = 1'b0;
    @(posedge up.pclk); #3;
    up.preset_n = 1'b1;

    cq.push_back('{2, 32'h1357_2468, 1'b0});
    xfer(1'b0, 32'h90, 32'h0, rd, er, lat);
    chk("t9_latency", lat, 5);
    chk("t9_prdata", rd, 32'h1357_2468);
    chk("t9_pslverr", er, 0);
    repeat (3) @(posedge up.pclk);
    chk("final_timeout_pulses", to_seen, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
